alu_rsp_deserializer: RTL and testbench
=======================================

# alu_rsp_deserializer

Synthesizable receiver for the ALU serial response line. Samples `sout` one bit per clock, reassembles 11-bit packets into a response (32-bit result C plus 8-bit ctl byte), and checks each response's CRC or error-frame parity. It sits directly downstream of the ALU output pin and presents one parallel, pre-checked response per transaction to the testbench monitor and scoreboard.

## Interface
- `DATA_PKTS`, default 4: data packets per normal response, sent MSB byte first.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sout`  in  1  serial response line; idles high.
- `rsp_valid`  out  1  one-cycle pulse; response outputs are updated in the same cycle.
- `rsp_C`  out  32  assembled result; 0 for error frames.
- `rsp_ctl`  out  8  received ctl byte.
- `rsp_err`  out  1  response is an error frame (`ctl[7]=1`).
- `rsp_chk_ok`  out  1  CRC match for a normal response; parity match for an error frame.
- `proto_err`  out  1  one-cycle pulse on a framing or sequence violation.

## Operation
- Packet format, 11 bits: start bit (0), type (0 = data, 1 = ctl), d7..d0, stop bit (1).
- Packet FSM states: IDLE, RX, WAIT_IDLE.
  - IDLE → RX when `sout=0`.
  - RX samples 10 bits using a 4-bit counter.
  - RX → IDLE at the stop sample if the stop bit is 1.
  - RX → WAIT_IDLE if the stop bit is 0.
  - WAIT_IDLE → IDLE when `sout=1`.
- Frame layer keeps a data count `cnt` (0..DATA_PKTS) and a 32-bit shift register.
- Data packet, `cnt<DATA_PKTS`: shift the byte in, `cnt++`.
- Data packet, `cnt=DATA_PKTS`: `proto_err`, `cnt←0`.
- Ctl packet, `cnt=DATA_PKTS` and `ctl[7]=0`: normal response.
  - `rsp_err=0`.
  - `rsp_chk_ok = (crc3({C,1'b0,ctl[6:3]}) == ctl[2:0])`.
- Ctl packet, `cnt=0` and `ctl[7]=1`: error response.
  - `rsp_C=0`, `rsp_err=1`.
  - `rsp_chk_ok = (ctl[0] == ~^ctl[6:1])`, i.e. `1 ^ xor(ctl[6:1])`.
- Any other ctl packet: `proto_err`, no `rsp_valid`.
- `cnt←0` after every ctl packet, every `proto_err`, and every bad stop bit.
- Bad stop bit: `proto_err`, partial frame discarded.
- CRC: polynomial x^3+x+1, init 0, 37 input bits fed MSB (`d[36]`) first; computed combinationally at the ctl packet.
- Response outputs hold their value between `rsp_valid` pulses.

## Timing
- Stop bit sampled in cycle k; `rsp_valid` and `proto_err` are registered and high in cycle k+1 only.
- Latency from the start-bit sample to `rsp_valid`: 11 cycles for the ctl packet.
- Back-to-back packets: a start bit in cycle k+1 is accepted with no idle gap.
- Reset values: all outputs 0, FSM in IDLE, `cnt=0`, shift register 0.
- Reset mid-packet or mid-frame: all partial data discarded; no pulse after release.
- Glitch rule: a 0 seen in IDLE always starts a packet; there is no start-bit mid-sampling.
- WAIT_IDLE ignores `sout=0`; this prevents a stuck-low line from re-triggering.

## Structure
- Shared `alu_pkg` holds:
  - the `PKT_DATA`/`PKT_CTL` type-bit constants;
  - the `rsp_t` struct `{C, ctl, err, chk_ok}`;
  - the `crc3_37` function, shared with the request-side CRC generator.
- Sub-module `alu_rx_packet` holds the bit-level FSM.
  - Outputs: `pkt_valid`, `pkt_type`, `pkt_byte`, `pkt_stop_err`.
- The top level holds the frame-sequencing logic and the checks.

## Test plan
- Normal: data packets 00,00,00,00 then ctl 0x16 (flags 0010, CRC 110) → `rsp_valid` 1 cycle after the stop bit, `rsp_C=0`, `rsp_ctl=0x16`, `rsp_err=0`, `rsp_chk_ok=1`.
- CRC fault: same frame with ctl 0x17 → `rsp_valid=1`, `rsp_chk_ok=0`.
- Error frame: a single ctl packet 0xC9 (flags 100100, parity 1) → `rsp_err=1`, `rsp_C=0`, `rsp_chk_ok=1`; the same frame with 0xC8 → `rsp_chk_ok=0`.
- Sequence errors, each → one `proto_err` pulse and no `rsp_valid`:
  - ctl packet after 2 data packets;
  - a 5th data packet;
  - ctl 0x16 arriving with `cnt=0`.
- Framing: stop bit 0 on packet 3, line held low 5 cycles, then a full valid frame → one `proto_err`, then a correct response.
- Reset: assert `rst_n` after 2 data packets, release, send a valid frame → outputs 0 during reset; exactly one `rsp_valid`, for the new frame only.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the request and response sides.
//   PKT_DATA / PKT_CTL : value of the type bit that follows a packet's start bit
//   pkt_state_t        : bit-level receiver states
//   rsp_t              : one assembled response {C, ctl, err, chk_ok}
//   crc3_37            : CRC-3 (x^3+x+1, init 0) over 37 bits, MSB first
package alu_pkg;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CTL  = 1'b1;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_RX,
    PK_WAIT_IDLE
  } pkt_state_t;

  typedef struct packed {
    logic [31:0] C;
    logic [7:0]  ctl;
    logic        err;
    logic        chk_ok;
  } rsp_t;

  // Serial LFSR form: feedback is the outgoing MSB xor the incoming bit,
  // folded back through the x^1 and x^0 taps.
  function automatic logic [2:0] crc3_37(input logic [36:0] d);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ d[i];
      crc = {crc[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_rx_packet.sv
// Bit-level receiver for one 11-bit packet: start(0), type, d7..d0, stop(1).
//   clk, rst_n    : clock, asynchronous active-low reset
//   sout          : serial line, idles high
//   pkt_valid     : high in the stop-bit sample cycle when the stop bit is 1
//   pkt_type      : received type bit (valid with pkt_valid)
//   pkt_byte      : received payload byte, d7 first (valid with pkt_valid)
//   pkt_stop_err  : high in the stop-bit sample cycle when the stop bit is 0
module alu_rx_packet
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sout,
  output logic       pkt_valid,
  output logic       pkt_type,
  output logic [7:0] pkt_byte,
  output logic       pkt_stop_err
);

  // Sample index within RX: 0 = type, 1..8 = d7..d0, 9 = stop.
  localparam logic [3:0] STOP_IDX = 4'd9;

  pkt_state_t state_q;
  logic [3:0] bit_cnt_q;
  logic       type_q;
  logic [7:0] byte_q;
  logic       stop_sample;

  // Packet strobes are decoded from the stop sample itself so the frame
  // layer can register its result on that same edge, which also lets a
  // start bit in the very next cycle be accepted.
  assign stop_sample  = (state_q == PK_RX) && (bit_cnt_q == STOP_IDX);
  assign pkt_valid    = stop_sample & sout;
  assign pkt_stop_err = stop_sample & ~sout;
  assign pkt_type     = type_q;
  assign pkt_byte     = byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PK_IDLE;
      bit_cnt_q <= '0;
      type_q    <= 1'b0;
      byte_q    <= '0;
    end else begin
      case (state_q)
        // Any low sample starts a packet; there is no mid-bit recheck.
        PK_IDLE: begin
          if (!sout) begin
            state_q   <= PK_RX;
            bit_cnt_q <= '0;
          end
        end
        PK_RX: begin
          if (bit_cnt_q == 4'd0) begin
            type_q <= sout;
          end else if (bit_cnt_q != STOP_IDX) begin
            byte_q <= {byte_q[6:0], sout};
          end
          if (bit_cnt_q == STOP_IDX) begin
            state_q <= sout ? PK_IDLE : PK_WAIT_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        // A line stuck low must return high before a new start is accepted.
        PK_WAIT_IDLE: begin
          if (sout) state_q <= PK_IDLE;
        end
        default: state_q <= PK_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_rsp_deserializer.sv
// ALU serial response receiver: reassembles packets into one checked response.
//   DATA_PKTS  : data packets per normal response, MSB byte first
//   clk, rst_n : clock, asynchronous active-low reset
//   sout       : serial response line, idles high
//   rsp_valid  : one-cycle pulse, response outputs updated in the same cycle
//   rsp_C      : assembled result (0 for error frames)
//   rsp_ctl    : received ctl byte
//   rsp_err    : response is an error frame (ctl[7]=1)
//   rsp_chk_ok : CRC match (normal) or parity match (error frame)
//   proto_err  : one-cycle pulse on a framing or sequence violation
module alu_rsp_deserializer
  import alu_pkg::*;
#(
  parameter int DATA_PKTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        rsp_valid,
  output logic [31:0] rsp_C,
  output logic [7:0]  rsp_ctl,
  output logic        rsp_err,
  output logic        rsp_chk_ok,
  output logic        proto_err
);

  localparam int               CNT_W    = $clog2(DATA_PKTS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_PKTS);

  logic       pkt_valid;
  logic       pkt_type;
  logic [7:0] pkt_byte;
  logic       pkt_stop_err;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sr_q, sr_d;
  rsp_t             rsp_q, rsp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             proto_err_q, proto_err_d;
  logic             crc_ok;
  logic             par_ok;

  alu_rx_packet u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .sout         (sout),
    .pkt_valid    (pkt_valid),
    .pkt_type     (pkt_type),
    .pkt_byte     (pkt_byte),
    .pkt_stop_err (pkt_stop_err)
  );

  // CRC covers the result plus a zero pad bit and the four flag bits.
  assign crc_ok = (crc3_37({sr_q, 1'b0, pkt_byte[6:3]}) == pkt_byte[2:0]);
  // Error frames carry odd parity over ctl[6:0].
  assign par_ok = (pkt_byte[0] == ~^pkt_byte[6:1]);

  always_comb begin
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    proto_err_d = 1'b0;
    if (pkt_stop_err) begin
      proto_err_d = 1'b1;
      cnt_d       = '0;
      sr_d        = '0;
    end else if (pkt_valid) begin
      case (pkt_type)
        PKT_DATA: begin
          if (cnt_q == CNT_FULL) begin
            proto_err_d = 1'b1;
            cnt_d       = '0;
            sr_d        = '0;
          end else begin
            sr_d  = {sr_q[23:0], pkt_byte};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PKT_CTL: begin
          cnt_d = '0;
          sr_d  = '0;
          if ((cnt_q == CNT_FULL) && !pkt_byte[7]) begin
            rsp_valid_d  = 1'b1;
            rsp_d.C      = sr_q;
            rsp_d.ctl    = pkt_byte;
            rsp_d.err    = 1'b0;
            rsp_d.chk_ok = crc_ok;
          end else if ((cnt_q == '0) && pkt_byte[7]) begin
            rsp_valid_d  = 1'b1;
            rsp_d.C      = '0;
            rsp_d.ctl    = pkt_byte;
            rsp_d.err    = 1'b1;
            rsp_d.chk_ok = par_ok;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_C      = rsp_q.C;
  assign rsp_ctl    = rsp_q.ctl;
  assign rsp_err    = rsp_q.err;
  assign rsp_chk_ok = rsp_q.chk_ok;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_alu_rsp_deserializer.sv
module tb_alu_rsp_deserializer;

  localparam int DP = 4;
  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sout = 1'b1;
  logic        rsp_valid;
  logic [31:0] rsp_C;
  logic [7:0]  rsp_ctl;
  logic        rsp_err;
  logic        rsp_chk_ok;
  logic        proto_err;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_proto = 0;

  // Expected held response (reference model state).
  logic [31:0] m_C = '0;
  logic [7:0]  m_ctl = '0;
  logic        m_err = 1'b0;
  logic        m_ok = 1'b0;
  logic [7:0]  dq[$];
  logic [9:0]  plist[$];

  typedef struct packed {
    logic [2:0]  n;
    logic [53:0] pks;   // up to six {type,byte} packets, first in the MSBs
    logic [1:0]  ev;
    logic [1:0]  ep;
    logic [31:0] C;
    logic [7:0]  ctl;
    logic        err;
    logic        ok;
  } vec_t;

  vec_t vecs [NV];

  alu_rsp_deserializer #(.DATA_PKTS(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sout       (sout),
    .rsp_valid  (rsp_valid),
    .rsp_C      (rsp_C),
    .rsp_ctl    (rsp_ctl),
    .rsp_err    (rsp_err),
    .rsp_chk_ok (rsp_chk_ok),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) n_valid++;
    if (proto_err === 1'b1) n_proto++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_hold(input string nm);
    chk({nm, "_C"},   rsp_C,             m_C);
    chk({nm, "_ctl"}, 32'(rsp_ctl),      32'(m_ctl));
    chk({nm, "_err"}, 32'(rsp_err),      32'(m_err));
    chk({nm, "_ok"},  32'(rsp_chk_ok),   32'(m_ok));
  endtask

  task automatic idle(input int n);
    sout = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] b, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, typ, b, stop};
    for (int i = 10; i >= 0; i--) begin
      sout = bits[i];
      @(posedge clk);
      #1;
    end
    sout = 1'b1;
  endtask

  // CRC as the remainder of polynomial division of d(x)*x^3 by x^3+x+1.
  function automatic logic [2:0] ref_crc(input logic [36:0] d);
    logic [39:0] r;
    r = {d, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r = r ^ (40'hB << (i - 3));
    return r[2:0];
  endfunction

  task automatic model_pkt(input logic typ, input logic [7:0] b, input logic stop,
                           output logic ev, output logic ep);
    logic [31:0] c;
    ev = 1'b0;
    ep = 1'b0;
    if (!stop) begin
      ep = 1'b1;
      dq.delete();
    end else if (!typ) begin
      if (dq.size() == DP) begin
        ep = 1'b1;
        dq.delete();
      end else begin
        dq.push_back(b);
      end
    end else begin
      if (dq.size() == DP && !b[7]) begin
        c = 0;
        for (int k = 0; k < DP; k++) c = (c << 8) | 32'(dq[k]);
        ev = 1'b1;
        m_C = c; m_ctl = b; m_err = 1'b0;
        m_ok = (ref_crc({c, 1'b0, b[6:3]}) == b[2:0]);
      end else if (dq.size() == 0 && b[7]) begin
        ev = 1'b1;
        m_C = 0; m_ctl = b; m_err = 1'b1;
        m_ok = ($countones(b[6:0]) % 2) == 1;
      end else begin
        ep = 1'b1;
      end
      dq.delete();
    end
  endtask

  function automatic vec_t mkv(input int n, input logic [53:0] pks, input int ev, input int ep,
                               input logic [31:0] c, input logic [7:0] ctl,
                               input logic err, input logic ok);
    vec_t v;
    v.n = 3'(n); v.pks = pks; v.ev = 2'(ev); v.ep = 2'(ep);
    v.C = c; v.ctl = ctl; v.err = err; v.ok = ok;
    return v;
  endfunction

  initial begin
    int v0, p0;
    logic [53:0] pks;
    logic [8:0]  pk;
    logic        ev, ep;

    vecs[0]  = mkv(5, {9'h000, 9'h000, 9'h000, 9'h000, 9'h116, 9'h000}, 1, 0, 32'h0, 8'h16, 1'b0, 1'b1);
    vecs[1]  = mkv(5, {9'h000, 9'h000, 9'h000, 9'h000, 9'h117, 9'h000}, 1, 0, 32'h0, 8'h17, 1'b0, 1'b0);
    vecs[2]  = mkv(5, {9'h000, 9'h000, 9'h000, 9'h001, 9'h102, 9'h000}, 1, 0, 32'h1, 8'h02, 1'b0, 1'b1);
    vecs[3]  = mkv(5, {9'h000, 9'h000, 9'h000, 9'h000, 9'h10B, 9'h000}, 1, 0, 32'h0, 8'h0B, 1'b0, 1'b1);
    vecs[4]  = mkv(1, {9'h1C9, 45'd0}, 1, 0, 32'h0, 8'hC9, 1'b1, 1'b1);
    vecs[5]  = mkv(1, {9'h1C8, 45'd0}, 1, 0, 32'h0, 8'hC8, 1'b1, 1'b0);
    vecs[6]  = mkv(1, {9'h181, 45'd0}, 1, 0, 32'h0, 8'h81, 1'b1, 1'b1);
    vecs[7]  = mkv(1, {9'h180, 45'd0}, 1, 0, 32'h0, 8'h80, 1'b1, 1'b0);
    vecs[8]  = mkv(3, {9'h011, 9'h022, 9'h116, 27'd0}, 0, 1, 32'h0, 8'h00, 1'b0, 1'b0);
    vecs[9]  = mkv(5, {9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h000}, 0, 1, 32'h0, 8'h00, 1'b0, 1'b0);
    vecs[10] = mkv(1, {9'h116, 45'd0}, 0, 1, 32'h0, 8'h00, 1'b0, 1'b0);

    // Reset state
    sout = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    chk_hold("rst");
    rst_n = 1'b1;
    idle(2);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      v0 = n_valid;
      p0 = n_proto;
      pks = vecs[i].pks;
      for (int j = 0; j < int'(vecs[i].n); j++) begin
        pk = pks[53 - 9*j -: 9];
        send_pkt(pk[8], pk[7:0], 1'b1);
        if (i % 2 == 1) idle(1);
      end
      idle(2);
      chk($sformatf("vec%0d_nvalid", i), 32'(n_valid - v0), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_nproto", i), 32'(n_proto - p0), 32'(vecs[i].ep));
      if (vecs[i].ev != 0) begin
        m_C = vecs[i].C; m_ctl = vecs[i].ctl; m_err = vecs[i].err; m_ok = vecs[i].ok;
      end
      chk_hold($sformatf("vec%0d", i));
    end

    // Latency and back-to-back frames with no idle gap
    v0 = n_valid;
    p0 = n_proto;
    for (int j = 0; j < 4; j++) send_pkt(1'b0, 8'h00, 1'b1);
    chk("b2b_data_no_valid", 32'(rsp_valid), 32'd0);
    send_pkt(1'b1, 8'h16, 1'b1);
    chk("b2b_lat_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_lat_ctl", 32'(rsp_ctl), 32'h16);
    send_pkt(1'b1, 8'hC9, 1'b1);
    chk("b2b_err_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_err_flag", 32'(rsp_err), 32'd1);
    idle(2);
    chk("b2b_nvalid", 32'(n_valid - v0), 32'd2);
    chk("b2b_nproto", 32'(n_proto - p0), 32'd0);
    m_C = 0; m_ctl = 8'hC9; m_err = 1'b1; m_ok = 1'b1;
    chk_hold("b2b");

    // Bad stop bit on packet 3, line stuck low, then a good frame
    v0 = n_valid;
    p0 = n_proto;
    send_pkt(1'b0, 8'h55, 1'b1);
    send_pkt(1'b0, 8'hAA, 1'b1);
    send_pkt(1'b0, 8'h33, 1'b0);
    chk("stop_proto_pulse", 32'(proto_err), 32'd1);
    sout = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    idle(1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h01, 1'b1);
    send_pkt(1'b1, 8'h02, 1'b1);
    idle(2);
    chk("stop_nproto", 32'(n_proto - p0), 32'd1);
    chk("stop_nvalid", 32'(n_valid - v0), 32'd1);
    m_C = 32'h1; m_ctl = 8'h02; m_err = 1'b0; m_ok = 1'b1;
    chk_hold("stop");

    // Reset mid-frame and mid-packet
    v0 = n_valid;
    p0 = n_proto;
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    sout = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      sout = 1'b1;
    end
    rst_n = 1'b0;
    sout = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_proto", 32'(proto_err), 32'd0);
    m_C = 0; m_ctl = 0; m_err = 0; m_ok = 0;
    chk_hold("mid_rst");
    rst_n = 1'b1;
    idle(2);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b0, 8'h01, 1'b1);
    send_pkt(1'b1, 8'h02, 1'b1);
    idle(2);
    chk("post_rst_nvalid", 32'(n_valid - v0), 32'd1);
    chk("post_rst_nproto", 32'(n_proto - p0), 32'd0);
    m_C = 32'h1; m_ctl = 8'h02; m_err = 1'b0; m_ok = 1'b1;
    chk_hold("post_rst");

    // Randomized frames against the reference model
    dq.delete();
    for (int f = 0; f < 150; f++) begin
      int kind;
      logic [31:0] c;
      logic [3:0]  flags;
      logic [2:0]  crc;
      logic [7:0]  b;
      plist.delete();
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        c = $urandom;
        for (int k = 3; k >= 0; k--) plist.push_back({2'b10, c[8*k +: 8]});
        flags = 4'($urandom_range(0, 15));
        crc = ref_crc({c, 1'b0, flags});
        if ($urandom_range(0, 3) == 0) crc = crc ^ 3'($urandom_range(1, 7));
        plist.push_back({2'b11, 1'b0, flags, crc});
      end else if (kind <= 6) begin
        b = 8'($urandom) | 8'h80;
        plist.push_back({2'b11, b});
      end else if (kind == 7) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++)
          plist.push_back({1'b1, 1'($urandom), 8'($urandom)});
      end else if (kind == 8) begin
        plist.push_back({1'b0, 1'($urandom), 8'($urandom)});
      end else begin
        for (int k = 0; k < int'($urandom_range(0, 5)); k++)
          plist.push_back({2'b10, 8'($urandom)});
        plist.push_back({2'b11, 8'($urandom)});
      end
      foreach (plist[k]) begin
        int gap;
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
        send_pkt(plist[k][8], plist[k][7:0], plist[k][9]);
        model_pkt(plist[k][8], plist[k][7:0], plist[k][9], ev, ep);
        chk("rnd_valid", 32'(rsp_valid), 32'(ev));
        chk("rnd_proto", 32'(proto_err), 32'(ep));
        chk_hold("rnd");
        if (!plist[k][9]) begin
          sout = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          idle(1);
        end
      end
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
